// File: rtl/im_fetch_buffer_if.sv
// Fetch buffer bus bundle. It groups the processor instruction port and the
// external memory port. The slave modport belongs to the buffer unit. The
// master modport is the surrounding system, meaning the processor plus the
// external memory.
interface im_fetch_buffer_if #(
  parameter int MSB_DATA = 16,
  parameter int MSB_RAM  = 10,
  parameter int LSB      = 0
);
  logic [LSB+MSB_RAM-1:LSB]  ADDR_im_i;
  logic                      CEnable_im_i;
  logic                      OEnable_im_i;
  logic [LSB+MSB_DATA-1:LSB] DATA_im_o;
  logic                      HOLD_n_i;
  logic                      HOLD_n_o;
  logic [LSB+MSB_RAM-1:LSB]  MEM_ADDR_o;
  logic                      MEM_CEn_o;
  logic                      MEM_OEn_o;
  logic [LSB+MSB_DATA-1:LSB] MEM_DATA_i;

  modport slave (
    input  ADDR_im_i, CEnable_im_i, OEnable_im_i, HOLD_n_i, MEM_DATA_i,
    output DATA_im_o, HOLD_n_o, MEM_ADDR_o, MEM_CEn_o, MEM_OEn_o
  );

  modport master (
    output ADDR_im_i, CEnable_im_i, OEnable_im_i, HOLD_n_i, MEM_DATA_i,
    input  DATA_im_o, HOLD_n_o, MEM_ADDR_o, MEM_CEn_o, MEM_OEn_o
  );
endinterface

// File: rtl/im_fetch_buffer.sv
// Instruction-memory fetch buffer.
// - A one-word buffer holds the last fetched address and data.
// - A hit serves the word without stalling.
// - A miss runs a wait-stated external read and holds the processor until
//   the word lands in the buffer.
// Build option IM_PREFETCH_EN:
// - The buffer becomes two entries with LRU replacement.
// - A hit on one entry prefetches the next sequential word into the other
//   entry, and that prefetch does not stall the processor.
module im_fetch_buffer #(
  parameter int MSB_DATA    = 16,
  parameter int MSB_RAM     = 10,
  parameter int WAIT_STATES = 3,
  parameter int LSB         = 0
) (
  input  logic             CLOCK_i,
  input  logic             RESET_n_i,
  im_fetch_buffer_if.slave bus
);
  localparam int         DW = MSB_DATA;
  localparam int         AW = MSB_RAM;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_cen;
  logic          r_mem_oen;
  logic          w_req;
  logic          w_hit;
  logic          w_miss;

  assign w_req  = ~bus.CEnable_im_i & ~bus.OEnable_im_i;
  assign w_miss = w_req & ~w_hit;

  // The stall is combinational, so the processor freezes in the miss cycle itself.
  // A prefetch in flight does not stall on its own.
  assign bus.HOLD_n_o   = bus.HOLD_n_i & ~(w_miss | (r_state == WAIT));
  assign bus.MEM_ADDR_o = r_mem_addr;
  assign bus.MEM_CEn_o  = r_mem_cen;
  assign bus.MEM_OEn_o  = r_mem_oen;

`ifndef IM_PREFETCH_EN
  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;

  assign w_hit         = r_valid & (r_tag == bus.ADDR_im_i);
  assign bus.DATA_im_o = r_data;

  // Single-entry fill FSM: a miss launches a read, and the last wait cycle fills the buffer.
  always_ff @(posedge CLOCK_i or negedge RESET_n_i) begin
    if (!RESET_n_i) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_mem_cen  <= 1'b1;
      r_mem_oen  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_miss) begin
          r_mem_addr <= bus.ADDR_im_i;
          r_mem_cen  <= 1'b0;
          r_mem_oen  <= 1'b0;
          r_cnt      <= WS;
          r_state    <= WAIT;
        end
        WAIT: if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_data    <= bus.MEM_DATA_i;
          r_tag     <= r_mem_addr;
          r_valid   <= 1'b1;
          r_mem_cen <= 1'b1;
          r_mem_oen <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  localparam logic [1:0] PREF = 2'd2;

  logic [1:0]         r_vld;
  logic [1:0][AW-1:0] r_tag;
  logic [1:0][DW-1:0] r_dat;
  logic               r_lru;   // entry to evict on the next demand miss
  logic               r_fill;  // entry targeted by the read in flight
  logic [1:0]         w_hit_v;
  logic               w_hx;
  logic               w_oth;
  logic               w_pf;
  logic [AW-1:0]      w_next;

  assign w_hit_v[0]    = r_vld[0] & (r_tag[0] == bus.ADDR_im_i);
  assign w_hit_v[1]    = r_vld[1] & (r_tag[1] == bus.ADDR_im_i);
  assign w_hit         = |w_hit_v;
  assign w_hx          = w_hit_v[1];
  assign w_oth         = ~w_hx;
  assign w_next        = r_tag[w_hx] + AW'(1);
  assign w_pf          = ~(r_vld[w_oth] & (r_tag[w_oth] == w_next));
  assign bus.DATA_im_o = r_dat[w_hx];

  // Two-entry fill FSM.
  // - A demand miss fills the LRU entry.
  // - A hit prefetches the next word into the other entry.
  // - A demand miss seen during a prefetch stalls through the fill.
  // - Back in IDLE, that request either hits or starts its own read.
  always_ff @(posedge CLOCK_i or negedge RESET_n_i) begin
    if (!RESET_n_i) begin
      r_state    <= IDLE;
      r_vld      <= '0;
      r_tag      <= '0;
      r_dat      <= '0;
      r_lru      <= 1'b0;
      r_fill     <= 1'b0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_mem_cen  <= 1'b1;
      r_mem_oen  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_miss) begin
          r_mem_addr <= bus.ADDR_im_i;
          r_mem_cen  <= 1'b0;
          r_mem_oen  <= 1'b0;
          r_cnt      <= WS;
          r_fill     <= r_lru;
          r_state    <= WAIT;
        end else if (w_req) begin
          r_lru <= w_oth;
          if (w_pf) begin
            r_mem_addr <= w_next;
            r_mem_cen  <= 1'b0;
            r_mem_oen  <= 1'b0;
            r_cnt      <= WS;
            r_fill     <= w_oth;
            r_state    <= PREF;
          end
        end
        WAIT, PREF: if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_dat[r_fill] <= bus.MEM_DATA_i;
          r_tag[r_fill] <= r_mem_addr;
          r_vld[r_fill] <= 1'b1;
          r_lru         <= ~r_fill;  // keep the freshly filled entry resident
          r_mem_cen     <= 1'b1;
          r_mem_oen     <= 1'b1;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`endif
endmodule
